npu_mem_sequencer: RTL and testbench

Parametrised second-generation NPU memory sequencer between the SPI front end, the dual-port weight/activation RAM and the layer compute engine. It decodes SPI traffic into configuration-register writes or a streamed load of port A. It owns the layer counter and generates activation write-back addresses across `NUM_ACT_BUFS` rotating buffers. It adds range-checked register decode, an explicit abort mode and N-way buffer rotation over the previous two-buffer scheme.

---
 rtl/npu_mem_sequencer_pkg.sv | 28 ++
 rtl/npu_mem_sequencer_act_addr_gen.sv | 64 ++++++
 rtl/npu_mem_sequencer.sv | 172 +++++++++++++++++
 tb/tb_npu_mem_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_mem_sequencer_pkg.sv
// Shared encodings for the NPU memory sequencer: SPI mode codes, FSM states,
// default activation-buffer placement and a select-width helper.
// No logic; imported by npu_mem_sequencer and npu_mem_sequencer_act_addr_gen.
package npu_mem_sequencer_pkg;

  localparam logic [1:0] MODE_IDLE   = 2'b00;
  localparam logic [1:0] MODE_STREAM = 2'b01;
  localparam logic [1:0] MODE_REG    = 2'b10;
  localparam logic [1:0] MODE_ABORT  = 2'b11;

  localparam int DEF_ACT_BASE   = 20400;
  localparam int DEF_ACT_STRIDE = 40;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_WAIT,
    S_DATA_WAIT,
    S_REG_WR,
    S_STREAM_WAIT,
    S_STREAM_WR
  } state_t;

  // Width of a buffer select; a single buffer still gets a 1-bit select.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/npu_mem_sequencer_act_addr_gen.sv
// Purpose: activation buffer rotation, write-back pointer and done compare.
// Latency: pointer/select update one cycle after the strobe; act_done is combinational on the pointer.
// Backpressure: none, every strobe is consumed in the cycle it is seen.
// Ports: layer_shift/first_preload/act_valid/tx_step strobes, neurons count in;
//        buf_sel, act_ptr, act_done out.
module npu_mem_sequencer_act_addr_gen
  import npu_mem_sequencer_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 15,
  parameter int NUM_ACT_BUFS = 2,
  parameter int ACT_BASE     = DEF_ACT_BASE,
  parameter int ACT_STRIDE   = DEF_ACT_STRIDE
) (
  input  logic                              clk,
  input  logic                              reset_b,
  input  logic                              layer_shift,
  input  logic                              first_preload,
  input  logic                              act_valid,
  input  logic                              tx_step,
  input  logic [DATA_W-1:0]                 neurons,
  output logic [sel_w(NUM_ACT_BUFS)-1:0]    buf_sel,
  output logic [ADDR_W-1:0]                 act_ptr,
  output logic                              act_done
);

  localparam int BUF_W = sel_w(NUM_ACT_BUFS);

  logic [BUF_W-1:0]  buf_sel_q, buf_sel_d;
  logic [ADDR_W-1:0] act_ptr_q, act_ptr_d;

  function automatic logic [ADDR_W-1:0] buf_base(input logic [BUF_W-1:0] sel);
    return ADDR_W'(ACT_BASE + int'(sel) * ACT_STRIDE);
  endfunction

  always_comb begin
    buf_sel_d = buf_sel_q;
    if (layer_shift) begin
      buf_sel_d = (int'(buf_sel_q) == NUM_ACT_BUFS - 1) ? '0 : buf_sel_q + BUF_W'(1);
    end
    // Preload wins over a coincident increment; a shift preloads from the new buffer.
    act_ptr_d = act_ptr_q;
    if (layer_shift | first_preload) begin
      act_ptr_d = buf_base(buf_sel_d);
    end else if (act_valid | tx_step) begin
      act_ptr_d = act_ptr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      buf_sel_q <= '0;
      act_ptr_q <= '0;
    end else begin
      buf_sel_q <= buf_sel_d;
      act_ptr_q <= act_ptr_d;
    end
  end

  assign buf_sel  = buf_sel_q;
  assign act_ptr  = act_ptr_q;
  assign act_done = (act_ptr_q == ADDR_W'(int'(buf_base(buf_sel_q)) + int'(neurons) - 1));

endmodule

// File: rtl/npu_mem_sequencer.sv
// Purpose: decode SPI traffic into config-register writes or a streamed port-A load; drive RAM addresses.
// Latency: port-A write one cycle after the last spi_valid; register update visible two cycles after it.
// Backpressure: none; spi_valid outside a WAIT state is dropped, mode 00/11 aborts to IDLE.
// Ports: mode/spi_* from SPI front end; init/layer_shift/first_preload/act_valid/tx_* from control;
//        compute_addr_a/b from compute engine; mem_a_*/mem_b_* to dual-port RAM; cfg/status out.
// Option: NPU_MEM_DEBUG_EN adds debug_we/debug_addr/debug_data which override port A.
module npu_mem_sequencer
  import npu_mem_sequencer_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 15,
  parameter int NUM_CFG_REGS = 4,
  parameter int NUM_ACT_BUFS = 2,
  parameter int ACT_BASE     = DEF_ACT_BASE,
  parameter int ACT_STRIDE   = DEF_ACT_STRIDE
) (
  input  logic                             clk,
  input  logic                             reset_b,
  input  logic [1:0]                       mode,
  input  logic [DATA_W-1:0]                spi_data,
  input  logic                             spi_valid,
  input  logic                             init,
  input  logic                             layer_shift,
  input  logic                             first_preload,
  input  logic                             act_valid,
  input  logic                             tx_active,
  input  logic                             tx_step,
  input  logic [DATA_W-1:0]                neurons,
  input  logic [ADDR_W-1:0]                compute_addr_a,
  input  logic [ADDR_W-1:0]                compute_addr_b,
`ifdef NPU_MEM_DEBUG_EN
  input  logic                             debug_we,
  input  logic [ADDR_W-1:0]                debug_addr,
  input  logic [DATA_W-1:0]                debug_data,
`endif
  output logic [ADDR_W-1:0]                mem_a_addr,
  output logic [ADDR_W-1:0]                mem_b_addr,
  output logic [DATA_W-1:0]                mem_a_wdata,
  output logic                             mem_a_we,
  output logic                             mem_b_we,
  output logic [NUM_CFG_REGS*DATA_W-1:0]   cfg_regs,
  output logic [DATA_W-1:0]                input_count,
  output logic [ADDR_W-1:0]                layer_idx,
  output logic [sel_w(NUM_ACT_BUFS)-1:0]   buf_sel,
  output logic                             last_layer,
  output logic                             act_done,
  output logic                             cfg_err
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] addr_q, addr_d, stage_q, stage_d, input_count_q, input_count_d;
  logic [DATA_W-1:0] cfg_q [NUM_CFG_REGS];
  logic [DATA_W-1:0] cfg_d [NUM_CFG_REGS];
  logic              cfg_err_q, cfg_err_d;
  logic [ADDR_W-1:0] stream_ptr_q, stream_ptr_d, layer_idx_q, layer_idx_d, act_ptr;
  logic              abort, reg_wr, stream_wr, addr_ok;

  // Mode 00/11 forces IDLE and suppresses any write pending in this cycle.
  assign abort     = (mode == MODE_IDLE) || (mode == MODE_ABORT);
  assign reg_wr    = (state_q == S_REG_WR) && !abort;
  assign stream_wr = (state_q == S_STREAM_WR) && !abort;
  assign addr_ok   = int'(addr_q) < NUM_CFG_REGS;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    stage_d = stage_q;
    case (state_q)
      S_IDLE, S_REG_WR, S_STREAM_WR: begin
        if (mode == MODE_REG)         state_d = S_ADDR_WAIT;
        else if (mode == MODE_STREAM) state_d = S_STREAM_WAIT;
        else                          state_d = S_IDLE;
      end
      S_ADDR_WAIT:   if (spi_valid) begin addr_d  = spi_data; state_d = S_DATA_WAIT;  end
      S_DATA_WAIT:   if (spi_valid) begin stage_d = spi_data; state_d = S_REG_WR;     end
      S_STREAM_WAIT: if (spi_valid) begin stage_d = spi_data; state_d = S_STREAM_WR;  end
      default:       state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d = S_IDLE;
      addr_d  = addr_q;
      stage_d = stage_q;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CFG_REGS; i++) begin
      cfg_d[i] = cfg_q[i];
      if (reg_wr && addr_q == DATA_W'(i)) cfg_d[i] = stage_q;
    end
    cfg_err_d = cfg_err_q;
    if (init)               cfg_err_d = 1'b0;
    if (reg_wr && !addr_ok) cfg_err_d = 1'b1;
    stream_ptr_d = stream_ptr_q;
    if (init)      stream_ptr_d = '0;
    if (stream_wr) stream_ptr_d = stream_ptr_q + ADDR_W'(1);
    input_count_d = (stream_wr && stream_ptr_q == '0) ? stage_q : input_count_q;
    layer_idx_d   = layer_shift ? layer_idx_q + ADDR_W'(1) : layer_idx_q;
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      stage_q       <= '0;
      cfg_err_q     <= 1'b0;
      stream_ptr_q  <= '0;
      input_count_q <= '0;
      layer_idx_q   <= '0;
      for (int i = 0; i < NUM_CFG_REGS; i++) cfg_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      stage_q       <= stage_d;
      cfg_err_q     <= cfg_err_d;
      stream_ptr_q  <= stream_ptr_d;
      input_count_q <= input_count_d;
      layer_idx_q   <= layer_idx_d;
      for (int i = 0; i < NUM_CFG_REGS; i++) cfg_q[i] <= cfg_d[i];
    end
  end

  always_comb begin
    mem_a_we    = stream_wr;
    mem_a_wdata = stage_q;
    if (stream_wr) mem_a_addr = stream_ptr_q;
    else if (init) mem_a_addr = layer_idx_q;
    else           mem_a_addr = compute_addr_a;
`ifdef NPU_MEM_DEBUG_EN
    // Debug access takes port A outright; a colliding stream word is lost.
    if (debug_we) begin
      mem_a_we    = 1'b1;
      mem_a_addr  = debug_addr;
      mem_a_wdata = debug_data;
    end
`endif
    mem_b_we = act_valid;
    if (act_valid | tx_active) mem_b_addr = act_ptr;
    else if (init)             mem_b_addr = layer_idx_q + ADDR_W'(1);
    else                       mem_b_addr = compute_addr_b;
  end

  for (genvar g = 0; g < NUM_CFG_REGS; g++) begin : g_cfg_flat
    assign cfg_regs[g*DATA_W +: DATA_W] = cfg_q[g];
  end

  assign cfg_err     = cfg_err_q;
  assign input_count = input_count_q;
  assign layer_idx   = layer_idx_q;
  // Register 0 holds num_layers; evaluated in int so num_layers==0 never matches.
  assign last_layer  = (int'(layer_idx_q) + 1 == int'(cfg_q[0]) - 1);

  npu_mem_sequencer_act_addr_gen #(
    .DATA_W       (DATA_W),
    .ADDR_W       (ADDR_W),
    .NUM_ACT_BUFS (NUM_ACT_BUFS),
    .ACT_BASE     (ACT_BASE),
    .ACT_STRIDE   (ACT_STRIDE)
  ) u_act_addr_gen (
    .clk           (clk),
    .reset_b       (reset_b),
    .layer_shift   (layer_shift),
    .first_preload (first_preload),
    .act_valid     (act_valid),
    .tx_step       (tx_step),
    .neurons       (neurons),
    .buf_sel       (buf_sel),
    .act_ptr       (act_ptr),
    .act_done      (act_done)
  );

endmodule

// File: tb/tb_npu_mem_sequencer.sv
// Randomised transaction-level bench for npu_mem_sequencer with an in-bench model
// of registers, stream pointer, layer counter and activation buffers.
module tb_npu_mem_sequencer;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 15;
  localparam int NCFG   = 4;
  localparam int NBUF   = 2;
  localparam int BASE   = 20400;
  localparam int STRIDE = 40;

  logic                   clk = 1'b0;
  logic                   reset_b;
  logic [1:0]             mode;
  logic [DATA_W-1:0]      spi_data;
  logic                   spi_valid, init, layer_shift, first_preload;
  logic                   act_valid, tx_active, tx_step;
  logic [DATA_W-1:0]      neurons;
  logic [ADDR_W-1:0]      compute_addr_a, compute_addr_b;
  logic [ADDR_W-1:0]      mem_a_addr, mem_b_addr, layer_idx;
  logic [DATA_W-1:0]      mem_a_wdata, input_count;
  logic                   mem_a_we, mem_b_we, last_layer, act_done, cfg_err;
  logic [NCFG*DATA_W-1:0] cfg_regs;
  logic [0:0]             buf_sel;

  always #5 clk = ~clk;

  npu_mem_sequencer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CFG_REGS(NCFG),
    .NUM_ACT_BUFS(NBUF), .ACT_BASE(BASE), .ACT_STRIDE(STRIDE)
  ) dut (
    .clk(clk), .reset_b(reset_b), .mode(mode), .spi_data(spi_data), .spi_valid(spi_valid),
    .init(init), .layer_shift(layer_shift), .first_preload(first_preload),
    .act_valid(act_valid), .tx_active(tx_active), .tx_step(tx_step), .neurons(neurons),
    .compute_addr_a(compute_addr_a), .compute_addr_b(compute_addr_b),
    .mem_a_addr(mem_a_addr), .mem_b_addr(mem_b_addr), .mem_a_wdata(mem_a_wdata),
    .mem_a_we(mem_a_we), .mem_b_we(mem_b_we), .cfg_regs(cfg_regs),
    .input_count(input_count), .layer_idx(layer_idx), .buf_sel(buf_sel),
    .last_layer(last_layer), .act_done(act_done), .cfg_err(cfg_err)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int m_cfg [NCFG];
  int m_err, m_sptr, m_icnt, m_layer, m_buf, m_act;
  logic [15:0] sq[$];

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int amask(input int v);
    return v & ((1 << ADDR_W) - 1);
  endfunction

  function automatic int bufbase(input int b);
    return amask(BASE + b * STRIDE);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 2)) tick();
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCFG; i++) m_cfg[i] = 0;
    m_err = 0; m_sptr = 0; m_icnt = 0; m_layer = 0; m_buf = 0; m_act = 0;
  endtask

  task automatic check_all();
    tx_active = 1'b1;
    #1;
    chk_eq("act_ptr", 32'(mem_b_addr), m_act);
    chk_eq("act_done", 32'(act_done), 32'(m_act == amask(bufbase(m_buf) + int'(neurons) - 1)));
    tx_active = 1'b0;
    #1;
    for (int i = 0; i < NCFG; i++) chk_eq("cfg_reg", 32'(cfg_regs[i*DATA_W +: DATA_W]), m_cfg[i]);
    chk_eq("cfg_err", 32'(cfg_err), m_err);
    chk_eq("input_count", 32'(input_count), m_icnt);
    chk_eq("layer_idx", 32'(layer_idx), m_layer);
    chk_eq("buf_sel", 32'(buf_sel), m_buf);
    chk_eq("last_layer", 32'(last_layer), 32'((m_layer + 1) == (m_cfg[0] - 1)));
    chk_eq("idle_a_we", 32'(mem_a_we), 0);
    chk_eq("idle_b_we", 32'(mem_b_we), 0);
    chk_eq("idle_a_addr", 32'(mem_a_addr), 32'(compute_addr_a));
    chk_eq("idle_b_addr", 32'(mem_b_addr), 32'(compute_addr_b));
  endtask

  task automatic reg_write(input int a, input int d);
    mode = 2'b10; tick();
    gap();
    spi_valid = 1'b1; spi_data = a[15:0]; tick(); spi_valid = 1'b0;
    gap();
    spi_valid = 1'b1; spi_data = d[15:0]; tick(); spi_valid = 1'b0;
    for (int i = 0; i < NCFG; i++) chk_eq("reg_not_early", 32'(cfg_regs[i*DATA_W +: DATA_W]), m_cfg[i]);
    chk_eq("reg_no_mem_we", 32'(mem_a_we), 0);
    tick();
    if (a < NCFG) m_cfg[a] = d & 16'hFFFF;
    else          m_err = 1;
    if (a < NCFG) chk_eq("reg_latency", 32'(cfg_regs[a*DATA_W +: DATA_W]), m_cfg[a]);
    mode = 2'b00; tick();
    check_all();
  endtask

  task automatic stream_run();
    mode = 2'b01; tick();
    foreach (sq[k]) begin
      gap();
      spi_valid = 1'b1; spi_data = sq[k]; tick();
      // spi_valid seen in STREAM_WR must be ignored
      spi_valid = 1'($urandom_range(0, 1)); spi_data = 16'($urandom);
      chk_eq("strm_we", 32'(mem_a_we), 1);
      chk_eq("strm_addr", 32'(mem_a_addr), m_sptr);
      chk_eq("strm_data", 32'(mem_a_wdata), 32'(sq[k]));
      if (m_sptr == 0) m_icnt = int'(sq[k]);
      m_sptr = amask(m_sptr + 1);
      tick(); spi_valid = 1'b0;
    end
    mode = 2'b00; tick();
    sq.delete();
    check_all();
  endtask

  task automatic do_shift(input bit with_av);
    layer_shift = 1'b1; act_valid = with_av;
    if (with_av) begin
      #1;
      chk_eq("shift_b_we", 32'(mem_b_we), 1);
      chk_eq("shift_b_addr", 32'(mem_b_addr), m_act);
    end
    tick(); layer_shift = 1'b0; act_valid = 1'b0;
    m_layer = amask(m_layer + 1);
    m_buf   = (m_buf + 1) % NBUF;
    m_act   = bufbase(m_buf);
    check_all();
  endtask

  task automatic do_preload();
    first_preload = 1'b1; tick(); first_preload = 1'b0;
    m_act = bufbase(m_buf);
    check_all();
  endtask

  task automatic do_step(input bit via_tx);
    if (via_tx) begin
      tx_active = 1'b1; tx_step = 1'b1;
    end else begin
      act_valid = 1'b1;
      #1;
      chk_eq("wb_b_we", 32'(mem_b_we), 1);
      chk_eq("wb_b_addr", 32'(mem_b_addr), m_act);
    end
    tick(); act_valid = 1'b0; tx_step = 1'b0; tx_active = 1'b0;
    m_act = amask(m_act + 1);
    check_all();
  endtask

  task automatic do_init();
    init = 1'b1;
    #1;
    chk_eq("init_a_addr", 32'(mem_a_addr), m_layer);
    chk_eq("init_b_addr", 32'(mem_b_addr), amask(m_layer + 1));
    tick(); init = 1'b0;
    m_err = 0; m_sptr = 0;
    check_all();
  endtask

  task automatic do_abort(input int a, input int d);
    mode = 2'b10; tick();
    spi_valid = 1'b1; spi_data = a[15:0]; tick();
    mode = 2'b11; spi_data = d[15:0]; tick();
    spi_valid = 1'b0;
    chk_eq("abort_a_we", 32'(mem_a_we), 0);
    mode = 2'b00; tick(); tick();
    check_all();
  endtask

  initial begin
    reset_b = 1'b0; mode = 2'b00; spi_data = '0; spi_valid = 1'b0; init = 1'b0;
    layer_shift = 1'b0; first_preload = 1'b0; act_valid = 1'b0; tx_active = 1'b0;
    tx_step = 1'b0; neurons = '0; compute_addr_a = '0; compute_addr_b = '0;
    model_reset();
    repeat (2) tick();
    check_all();
    chk_eq("rst_input_count", 32'(input_count), 0);
    reset_b = 1'b1;
    tick();

    // Directed items
    reg_write(0, 5);
    reg_write(9, 16'h1234);
    chk_eq("err_sticky", 32'(cfg_err), 1);
    do_init();
    sq.push_back(16'h0003); sq.push_back(16'hAAAA); sq.push_back(16'hBBBB);
    stream_run();
    do_shift(1'b0);
    do_shift(1'b0);
    neurons = 16'd3;
    repeat (3) do_step(1'b0);
    do_abort(1, 16'h7777);
    do_shift(1'b1);

    // init coinciding with a stream write must not block it
    mode = 2'b01; tick();
    spi_valid = 1'b1; spi_data = 16'h5A5A; tick(); spi_valid = 1'b0;
    init = 1'b1;
    #1;
    chk_eq("init_strm_we", 32'(mem_a_we), 1);
    chk_eq("init_strm_addr", 32'(mem_a_addr), m_sptr);
    if (m_sptr == 0) m_icnt = 16'h5A5A;
    tick(); init = 1'b0; mode = 2'b00; tick();
    do_init();

    // Reset in the middle of a register transaction
    mode = 2'b10; tick();
    spi_valid = 1'b1; spi_data = 16'd1; tick(); spi_valid = 1'b0; mode = 2'b00;
    reset_b = 1'b0;
    model_reset();
    tick();
    check_all();
    reset_b = 1'b1;
    tick();
    reg_write(2, 16'hC0DE);

    // Randomised traffic
    for (int it = 0; it < 300; it++) begin
      int op, a;
      compute_addr_a = 15'($urandom);
      compute_addr_b = 15'($urandom);
      op = $urandom_range(0, 9);
      case (op)
        0, 1: begin
          a = $urandom_range(0, 5);
          if (a == 5) a = 65535;
          reg_write(a, (a == 0) ? $urandom_range(0, 6) : int'($urandom & 32'hFFFF));
        end
        2: begin
          repeat ($urandom_range(1, 4)) sq.push_back(16'($urandom));
          stream_run();
        end
        3: do_shift(1'($urandom_range(0, 1)));
        4: do_preload();
        5, 6: do_step(1'($urandom_range(0, 1)));
        7: do_init();
        8: do_abort($urandom_range(0, 3), int'($urandom & 32'hFFFF));
        default: begin
          neurons = 16'($urandom_range(1, 6));
          tick();
          check_all();
        end
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
